data_fifo_flex: RTL
===================

Name: data_fifo_flex

Overview:
- Parametrised synchronous FIFO; next generation of the team's one-deep data buffer.
- Adds:
  - arbitrary power-of-two depth
  - occupancy count
  - programmable almost-full/almost-empty flags
  - synchronous flush
  - sticky overflow/underflow error flags
  - registered read-valid
- Used between pipeline stages and bus adapters wherever more than one word of slack is needed.

Parameters:
- DataWidth, 64, width of each stored word.
- Depth, 16, number of entries; power of two, >= 2.
- AlmostFullThr, 12, WAlmostFull asserts when Count >= this value; range 1..Depth.
- AlmostEmptyThr, 2, RAlmostEmpty asserts when Count <= this value; range 0..Depth-1.

Ports:
- Clk  input  1  rising-edge clock; the only clock.
- Rst  input  1  synchronous, active-high reset.
- Flush  input  1  synchronous clear of all contents.
- WData  input  DataWidth  write data.
- WInc  input  1  write request.
- WFull  output  1  FIFO full.
- WAlmostFull  output  1  Count >= AlmostFullThr.
- RInc  input  1  read request.
- RData  output  DataWidth  read data.
- RValid  output  1  RData holds a newly popped word.
- REmpty  output  1  FIFO empty.
- RAlmostEmpty  output  1  Count <= AlmostEmptyThr.
- Count  output  $clog2(Depth)+1  current occupancy, 0..Depth.
- Overflow  output  1  sticky: a write was attempted while full.
- Underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- One clock (Clk). Reset is synchronous and active-high (Rst), sampled on the Clk rising edge only.
- Reset values:
  - write/read pointers 0, Count 0, WFull 0, REmpty 1
  - WAlmostFull 0, RAlmostEmpty 1, RValid 0, RData 0, Overflow 0, Underflow 0
  - memory contents are not reset.
- Pointers are $clog2(Depth)+1 bits. The MSB is the wrap bit.
  - REmpty = pointers equal.
  - WFull = wrap bits differ and address bits equal.
- Accepted write = WInc & ~WFull. Memory is written only on an accepted write, then the write pointer increments.
- Accepted read = RInc & ~REmpty. The read pointer increments.
- WFull and REmpty are evaluated on pre-edge state. Consequences:
  - Full with WInc & RInc: the read is accepted, the write is dropped, Count goes Depth-1.
  - Empty with WInc & RInc: the write is accepted, the read is dropped, Count goes 1.
  - Neither full nor empty with both requests: both are accepted and Count is unchanged.
- Count: +1 on write-only, -1 on read-only. Flags are combinational from Count/pointers, with no extra latency.
- Read latency 1 cycle:
  - On the edge after an accepted read, RData = popped word and RValid = 1 for exactly one cycle.
  - Otherwise RValid = 0 and RData holds its last value.
- Pointers wrap modulo 2*Depth with no special handling; back-to-back traffic across the wrap must be seamless.
- Overflow sets on WInc & WFull. Underflow sets on RInc & REmpty. Both stay set until Rst or Flush.
- Flush:
  - Effect: same as reset on pointers, Count, RValid, RData, Overflow and Underflow, one edge.
  - Priority: it has priority over same-cycle WInc/RInc, which are dropped and do not set error flags.
- Rst has priority over Flush. Reset mid-traffic discards all contents; the next cycle is the empty state.

Optional Feature:
- DATA_FIFO_FWFT_EN defined: first-word-fall-through mode.
  - RData = head entry, read combinationally from memory at the read address.
  - RValid = ~REmpty.
  - RInc pops with zero latency, so the word is consumed in the cycle RInc is high.
  - Reset/Flush give RValid 0; RData is don't-care while REmpty.
- DATA_FIFO_FWFT_EN undefined: registered 1-cycle read exactly as above.
- Flags, Count and error behaviour are identical in both modes.

Decomposition:
- Package data_fifo_pkg:
  - fifo_status_t packed struct {full, empty, almost_full, almost_empty, overflow, underflow}
  - localparam helper function for pointer-width computation
- Sub-module fifo_ptr_ctrl: owns both pointers, Count, the full/empty/almost/error flags and the flush/reset priority. It exposes write/read addresses and accepted-write/accepted-read strobes.
- The top level holds the memory array and the read-data path (registered or FWFT).

Test Plan:
- Reset/empty read: Rst, then RInc=1 for 1 cycle -> REmpty=1, Count=0, RValid stays 0, Underflow=1, pointers unchanged.
- Fill to full: write 0x10..0x1F (16 words, Depth=16) -> WAlmostFull rises when Count reaches 12, WFull after the 16th. A 17th WInc sets Overflow, Count stays 16, and the stored data is unchanged.
- Drain with wrap: from full, pop 16 then push/pop 40 words with continuous RInc & WInc -> RData sequence matches write order across the pointer wrap. RValid follows each pop by 1 cycle (0 cycles under DATA_FIFO_FWFT_EN).
- Simultaneous access at full: Count=16, WInc=RInc=1 -> Count=15, the head word is popped and the new word is dropped. At Count=5 with both requests, Count stays 5.
- Flush mid-stream: Count=7, Overflow=1, assert Flush with WInc=1 -> next cycle Count=0, REmpty=1, Overflow=0, and the written word is not stored.
- Almost-empty threshold: Count walks 4->3->2->1 -> RAlmostEmpty asserts at 2 and remains asserted at 1 and 0.

Source files
------------

// File: rtl/data_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_fifo_pkg
//  Description : Shared types and helpers for the data_fifo_flex FIFO.
//                Optional macro used by the family: DATA_FIFO_FWFT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
package data_fifo_pkg;

    // Status bundle produced by the pointer controller.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ptr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ptr_ctrl
//  Description : Write/read pointers, occupancy, full/empty/almost flags and
//                sticky error flags for data_fifo_flex. Rst beats Flush, and
//                Flush beats same-cycle requests.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr_ctrl
    import data_fifo_pkg::*;
#(
    parameter int DEPTH            = 16,
    parameter int ALMOST_FULL_THR  = 12,
    parameter int ALMOST_EMPTY_THR = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_flush,
    input  logic                          i_winc,
    input  logic                          i_rinc,
    output logic [$clog2(DEPTH)-1:0]      o_waddr,
    output logic [$clog2(DEPTH)-1:0]      o_raddr,
    output logic                          o_wr_en,
    output logic                          o_rd_en,
    output logic [ptr_width(DEPTH)-1:0]   o_count,
    output fifo_status_t                  o_status
);

    localparam int c_pw = ptr_width(DEPTH);
    localparam int c_aw = c_pw - 1;
    localparam logic [c_pw-1:0] c_af_thr = c_pw'(ALMOST_FULL_THR);
    localparam logic [c_pw-1:0] c_ae_thr = c_pw'(ALMOST_EMPTY_THR);

    logic [c_pw-1:0] r_wptr;
    logic [c_pw-1:0] r_rptr;
    logic            r_overflow;
    logic            r_underflow;
    logic            w_full;
    logic            w_empty;
    logic            w_wr_en;
    logic            w_rd_en;
    logic [c_pw-1:0] w_count;

    // Full/empty from pre-edge pointers; the wrap bit disambiguates the two.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                     (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);

    // Occupancy falls out of modulo-2*DEPTH pointer difference.
    assign w_count = r_wptr - r_rptr;

    assign w_wr_en = i_winc & ~w_full  & ~i_flush & ~rst;
    assign w_rd_en = i_rinc & ~w_empty & ~i_flush & ~rst;

    // Pointer advance; reset and flush both return to the empty state.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_en) r_wptr <= r_wptr + 1'b1;
            if (w_rd_en) r_rptr <= r_rptr + 1'b1;
        end
    end

    // Sticky error flags; requests dropped by a flush do not count as errors.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (i_winc && w_full)  r_overflow  <= 1'b1;
            if (i_rinc && w_empty) r_underflow <= 1'b1;
        end
    end

    assign o_waddr = r_wptr[c_aw-1:0];
    assign o_raddr = r_rptr[c_aw-1:0];
    assign o_wr_en = w_wr_en;
    assign o_rd_en = w_rd_en;
    assign o_count = w_count;

    assign o_status.full         = w_full;
    assign o_status.empty        = w_empty;
    assign o_status.almost_full  = (w_count >= c_af_thr);
    assign o_status.almost_empty = (w_count <= c_ae_thr);
    assign o_status.overflow     = r_overflow;
    assign o_status.underflow    = r_underflow;

endmodule
`default_nettype wire

// File: rtl/data_fifo_flex.sv
`default_nettype none
// ============================================================================
//  Module      : data_fifo_flex
//  Description : Parametrised synchronous FIFO with occupancy count,
//                almost-full/almost-empty flags, flush and sticky errors.
//                Define DATA_FIFO_FWFT_EN for first-word-fall-through reads;
//                otherwise reads are registered with one cycle of latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_fifo_flex
    import data_fifo_pkg::*;
#(
    parameter int DataWidth      = 64,
    parameter int Depth          = 16,
    parameter int AlmostFullThr  = 12,
    parameter int AlmostEmptyThr = 2
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          Flush,
    input  logic [DataWidth-1:0]          WData,
    input  logic                          WInc,
    output logic                          WFull,
    output logic                          WAlmostFull,
    input  logic                          RInc,
    output logic [DataWidth-1:0]          RData,
    output logic                          RValid,
    output logic                          REmpty,
    output logic                          RAlmostEmpty,
    output logic [ptr_width(Depth)-1:0]   Count,
    output logic                          Overflow,
    output logic                          Underflow
);

    localparam int c_aw = $clog2(Depth);

    logic [DataWidth-1:0] r_mem [Depth];
    logic [c_aw-1:0]      w_waddr;
    logic [c_aw-1:0]      w_raddr;
    logic                 w_wr_en;
    logic                 w_rd_en;
    fifo_status_t         w_status;

    fifo_ptr_ctrl #(
        .DEPTH            (Depth),
        .ALMOST_FULL_THR  (AlmostFullThr),
        .ALMOST_EMPTY_THR (AlmostEmptyThr)
    ) u_ptr_ctrl (
        .clk      (Clk),
        .rst      (Rst),
        .i_flush  (Flush),
        .i_winc   (WInc),
        .i_rinc   (RInc),
        .o_waddr  (w_waddr),
        .o_raddr  (w_raddr),
        .o_wr_en  (w_wr_en),
        .o_rd_en  (w_rd_en),
        .o_count  (Count),
        .o_status (w_status)
    );

    assign WFull        = w_status.full;
    assign WAlmostFull  = w_status.almost_full;
    assign REmpty       = w_status.empty;
    assign RAlmostEmpty = w_status.almost_empty;
    assign Overflow     = w_status.overflow;
    assign Underflow    = w_status.underflow;

    // Storage array; written only on accepted writes, never reset.
    always_ff @(posedge Clk) begin
        if (w_wr_en) r_mem[w_waddr] <= WData;
    end

`ifdef DATA_FIFO_FWFT_EN
    // Head entry is presented directly; a pop consumes it in the same cycle.
    assign RData  = r_mem[w_raddr];
    assign RValid = ~w_status.empty;
`else
    logic [DataWidth-1:0] r_rdata;
    logic                 r_rvalid;

    // Registered read: popped word appears one edge after the accepted read.
    always_ff @(posedge Clk) begin
        if (Rst || Flush) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd_en;
            if (w_rd_en) r_rdata <= r_mem[w_raddr];
        end
    end

    assign RData  = r_rdata;
    assign RValid = r_rvalid;
`endif

endmodule
`default_nettype wire
